i2c_bit_controller: RTL and testbench

Command-driven I2C master sequencer that sits above the bus clock divider and turns START, WRITE, READ and STOP commands into open-drain SCL/SDA waveforms. It owns the SCL timing, supports repeated START and slave clock stretching, and returns one response per command. A byte-level host FSM or register front-end drives it over a valid/ready command port.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_bit_controller_if.sv | 22 ++
 rtl/i2c_quarter_timer.sv | 31 +++
 rtl/i2c_bit_controller.sv | 179 +++++++++++++++++
 tb/tb_i2c_bit_controller.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C bit-level master.
// Command opcodes, controller states and quarter index.
package i2c_pkg;

  typedef enum logic [1:0] {
    I2C_START = 2'b00,
    I2C_WRITE = 2'b01,
    I2C_READ  = 2'b10,
    I2C_STOP  = 2'b11
  } i2c_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } i2c_state_e;

  typedef logic [1:0] quarter_t;

endpackage

// File: rtl/i2c_bit_controller_if.sv
// Command/response port of the I2C bit controller.
// master = host side, slave = controller side.
interface i2c_bit_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_nack,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_nack,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack
  );
endinterface

// File: rtl/i2c_quarter_timer.sv
// Quarter-period down counter with load and stretch hold.
// quarter_done ticks on the last cycle of each quarter.
module i2c_quarter_timer #(
  parameter int QUARTER = 25
) (
  input  logic clk,
  input  logic rst_,
  input  logic load,
  input  logic hold,
  output logic quarter_done,
  output logic quarter_first
);

  localparam logic [7:0] RELOAD = 8'(QUARTER - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt <= RELOAD;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (!hold) begin
      cnt <= (cnt == 8'd0) ? RELOAD : cnt - 8'd1;
    end
  end

  assign quarter_done  = (cnt == 8'd0) && !hold && !load;
  assign quarter_first = (cnt == RELOAD);

endmodule

// File: rtl/i2c_bit_controller.sv
// I2C master sequencer: START/WRITE/READ/STOP commands
// to open-drain SCL/SDA enables with clock stretching.
module i2c_bit_controller
  import i2c_pkg::*;
#(
  parameter int QUARTER = 25
) (
  input  logic                 clk,
  input  logic                 rst_,
  i2c_bit_controller_if.slave  cmd,
  output logic                 busy,
  output logic                 bus_owned,
  output logic                 scl_oe,
  output logic                 sda_oe,
  input  logic                 scl_in,
  input  logic                 sda_in
);

  i2c_state_e state, state_d;
  quarter_t   q, q_d;
  logic [2:0] bitc, bitc_d;
  i2c_op_e    op, op_d;
  logic [7:0] tx, tx_d;
  logic [7:0] rx, rx_d;
  logic       nack, nack_d;
  logic       ack, ack_d;
  logic       own_d;
  logic       scl_d, sda_d;
  logic       idle, load, hold;
  logic       qdone, qfirst, sample;

  assign idle = (state == S_IDLE) || (state == S_DONE);
  assign busy = !idle;

  assign cmd.cmd_ready = idle;
  assign cmd.rsp_valid = (state == S_DONE);
  assign cmd.rsp_data  =
    (state == S_DONE && op == I2C_READ) ? rx : 8'h00;
  assign cmd.rsp_nack  =
    (state == S_DONE) && (op == I2C_WRITE) && ack;

  // Slave may stretch only once we have released SCL in Q2.
  assign hold   = busy && (q == 2'd2) && !scl_oe && !scl_in;
  assign sample = qfirst && (q == 2'd3) &&
                  (state == S_BIT || state == S_ACK);

  i2c_quarter_timer #(.QUARTER(QUARTER)) u_timer (
    .clk           (clk),
    .rst_          (rst_),
    .load          (load),
    .hold          (hold),
    .quarter_done  (qdone),
    .quarter_first (qfirst)
  );

  // {scl_oe, sda_oe} for a given state/quarter.
  function automatic logic [1:0] drive(
    input i2c_state_e s,
    input quarter_t   qq,
    input logic [2:0] b,
    input i2c_op_e    o,
    input logic [7:0] d,
    input logic       nk,
    input logic       own
  );
    logic [1:0] v;
    v = {own, 1'b0};
    unique case (1'b1)
      (s == S_START): begin
        unique case (qq)
          2'd0:    v = {own, 1'b0};
          2'd1:    v = 2'b00;
          2'd2:    v = 2'b01;
          default: v = 2'b11;
        endcase
      end
      (s == S_STOP): begin
        unique case (qq)
          2'd0:    v = 2'b11;
          2'd3:    v = 2'b00;
          default: v = 2'b01;
        endcase
      end
      (s == S_BIT):
        v = {!qq[1], (o == I2C_WRITE) && !d[3'd7 - b]};
      (s == S_ACK):
        v = {!qq[1], (o == I2C_READ) && !nk};
      default: ;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d = state;
    q_d     = q;
    bitc_d  = bitc;
    op_d    = op;
    tx_d    = tx;
    rx_d    = rx;
    nack_d  = nack;
    ack_d   = ack;
    own_d   = bus_owned;
    load    = 1'b0;
    if (idle) begin
      state_d = S_IDLE;
      if (cmd.cmd_valid) begin
        load   = 1'b1;
        q_d    = 2'd0;
        bitc_d = 3'd0;
        op_d   = i2c_op_e'(cmd.cmd_op);
        tx_d   = cmd.cmd_data;
        nack_d = cmd.cmd_nack;
        rx_d   = 8'h00;
        ack_d  = 1'b0;
        unique case (1'b1)
          (cmd.cmd_op == I2C_START): state_d = S_START;
          (cmd.cmd_op == I2C_STOP):  state_d = S_STOP;
          default:                   state_d = S_BIT;
        endcase
      end
    end else begin
      if (sample) begin
        if (state == S_BIT) rx_d = {rx[6:0], sda_in};
        else                ack_d = sda_in;
      end
      if (qdone) begin
        q_d = q + 2'd1;
        if (q == 2'd3) begin
          unique case (1'b1)
            (state == S_BIT): begin
              if (bitc == 3'd7) state_d = S_ACK;
              else              bitc_d  = bitc + 3'd1;
            end
            (state == S_START): begin
              state_d = S_DONE;
              own_d   = 1'b1;
            end
            (state == S_STOP): begin
              state_d = S_DONE;
              own_d   = 1'b0;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
    end
    {scl_d, sda_d} = drive(state_d, q_d, bitc_d, op_d,
                           tx_d, nack_d, own_d);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= S_IDLE;
      q         <= 2'd0;
      bitc      <= 3'd0;
      op        <= I2C_START;
      tx        <= 8'h00;
      rx        <= 8'h00;
      nack      <= 1'b0;
      ack       <= 1'b0;
      bus_owned <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      state     <= state_d;
      q         <= q_d;
      bitc      <= bitc_d;
      op        <= op_d;
      tx        <= tx_d;
      rx        <= rx_d;
      nack      <= nack_d;
      ack       <= ack_d;
      bus_owned <= own_d;
      scl_oe    <= scl_d;
      sda_oe    <= sda_d;
    end
  end

endmodule

// File: tb/tb_i2c_bit_controller.sv
// Directed bench for i2c_bit_controller, QUARTER=4,
// with a behavioural slave on the wired-AND lines.
module tb_i2c_bit_controller;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic rst_;
  logic busy, bus_owned, scl_oe, sda_oe;
  logic scl_in, sda_in;
  logic stretch = 1'b0;
  logic slave_low = 1'b0;
  int   checks = 0;
  int   errors = 0;

  i2c_bit_controller_if cmd_if ();

  assign scl_in = !scl_oe && !stretch;
  assign sda_in = !sda_oe && !slave_low;

  always #5 clk = ~clk;

  i2c_bit_controller #(.QUARTER(4)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .cmd       (cmd_if),
    .busy      (busy),
    .bus_owned (bus_owned),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .scl_in    (scl_in),
    .sda_in    (sda_in)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and step until rsp_valid; slave acts on lines.
  task automatic run(
    input  logic [1:0] op,
    input  logic [7:0] data,
    input  logic       nk,
    input  logic [7:0] sbyte,
    input  logic       sack,
    input  int         sbit,
    input  bit         junk,
    output int         lat,
    output logic [7:0] seen,
    output logic       ack_seen,
    output logic       q0_scl,
    output logic       scond,
    output logic       pcond,
    output logic       b1,
    output logic       r1
  );
    int   bitn, scnt;
    logic ps, pd, poe, ls, ld;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_nack  = nk;
    stretch   = 1'b0;
    scnt      = 0;
    bitn      = 0;
    slave_low = (op == I2C_READ) ? !sbyte[7] : 1'b0;
    ps  = !scl_oe && !stretch;
    pd  = !sda_oe && !slave_low;
    poe = scl_oe;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    lat = 1;
    b1 = busy;
    r1 = cmd_if.cmd_ready;
    q0_scl = scl_oe;
    seen = 8'h00;
    ack_seen = 1'b1;
    scond = 1'b0;
    pcond = 1'b0;
    while (1) begin
      if (stretch) begin
        scnt--;
        if (scnt == 0) stretch = 1'b0;
      end
      if (poe && !scl_oe && bitn == sbit) begin
        stretch = 1'b1;
        scnt = 10;
      end
      ls = !scl_oe && !stretch;
      if (ps && !ls) begin
        bitn++;
        if (op == I2C_READ && bitn < 8)
          slave_low = !sbyte[7 - bitn];
        else
          slave_low = (op == I2C_WRITE) && (bitn == 8) && sack;
      end
      ld = !sda_oe && !slave_low;
      if (!ps && ls) begin
        if (bitn < 8) seen = {seen[6:0], ld};
        else if (bitn == 8) ack_seen = ld;
      end
      if (ps && ls && pd && !ld) scond = 1'b1;
      if (ps && ls && !pd && ld) pcond = 1'b1;
      if (junk && lat == 5) begin
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = I2C_STOP;
      end
      if (junk && lat == 50) cmd_if.cmd_valid = 1'b0;
      ps = ls;
      pd = ld;
      poe = scl_oe;
      if (cmd_if.rsp_valid || lat >= 2000) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  int         lat, extra;
  logic [7:0] seen;
  logic       acks, q0, sc, pc, b1, r1;

  initial begin
    rst_ = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_data  = 8'h00;
    cmd_if.cmd_nack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_ready", cmd_if.cmd_ready, 1);
    chk("rst_rsp_valid", cmd_if.rsp_valid, 0);
    chk("rst_rsp_data", cmd_if.rsp_data, 0);
    chk("rst_rsp_nack", cmd_if.rsp_nack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owned", bus_owned, 0);
    @(negedge clk);
    rst_ = 1'b1;

    run(I2C_START, 8'h00, 0, 8'h00, 0, -1, 0,
        lat, seen, acks, q0, sc, pc, b1, r1);
    chk("start_lat", lat, 17);
    chk("start_busy1", b1, 1);
    chk("start_ready1", r1, 0);
    chk("start_q0_scl", q0, 0);
    chk("start_cond", sc, 1);
    chk("start_scl_after", scl_oe, 1);
    chk("start_owned", bus_owned, 1);
    chk("start_busy_rsp", busy, 0);
    chk("start_ready_rsp", cmd_if.cmd_ready, 1);

    run(I2C_WRITE, 8'hA5, 0, 8'h00, 1, -1, 0,
        lat, seen, acks, q0, sc, pc, b1, r1);
    chk("wr_a5_lat", lat, 145);
    chk("wr_a5_pattern", seen, 8'hA5);
    chk("wr_a5_nack", cmd_if.rsp_nack, 0);
    chk("wr_a5_data", cmd_if.rsp_data, 0);
    chk("wr_a5_nostart", sc, 0);

    run(I2C_WRITE, 8'h5A, 0, 8'h00, 0, -1, 0,
        lat, seen, acks, q0, sc, pc, b1, r1);
    chk("wr_5a_pattern", seen, 8'h5A);
    chk("wr_5a_nack", cmd_if.rsp_nack, 1);

    run(I2C_READ, 8'h00, 1, 8'h3C, 0, -1, 0,
        lat, seen, acks, q0, sc, pc, b1, r1);
    chk("rd_3c_lat", lat, 145);
    chk("rd_3c_data", cmd_if.rsp_data, 8'h3C);
    chk("rd_3c_ack_sda", acks, 1);
    chk("rd_3c_nack", cmd_if.rsp_nack, 0);

    run(I2C_READ, 8'h00, 0, 8'hC3, 0, -1, 0,
        lat, seen, acks, q0, sc, pc, b1, r1);
    chk("rd_c3_data", cmd_if.rsp_data, 8'hC3);
    chk("rd_c3_ack_sda", acks, 0);

    run(I2C_START, 8'h00, 0, 8'h00, 0, -1, 0,
        lat, seen, acks, q0, sc, pc, b1, r1);
    chk("rstart_lat", lat, 17);
    chk("rstart_q0_scl", q0, 1);
    chk("rstart_cond", sc, 1);
    chk("rstart_owned", bus_owned, 1);

    run(I2C_WRITE, 8'h96, 0, 8'h00, 1, 3, 1,
        lat, seen, acks, q0, sc, pc, b1, r1);
    chk("stretch_lat", lat, 155);
    chk("stretch_pattern", seen, 8'h96);
    chk("stretch_nack", cmd_if.rsp_nack, 0);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (cmd_if.rsp_valid) extra++;
    end
    chk("junk_extra_rsp", extra, 0);
    chk("junk_owned", bus_owned, 1);
    chk("junk_idle", busy, 0);

    run(I2C_STOP, 8'h00, 0, 8'h00, 0, -1, 0,
        lat, seen, acks, q0, sc, pc, b1, r1);
    chk("stop_lat", lat, 17);
    chk("stop_cond", pc, 1);
    chk("stop_owned", bus_owned, 0);
    chk("stop_scl_oe", scl_oe, 0);
    chk("stop_sda_oe", sda_oe, 0);

    run(I2C_START, 8'h00, 0, 8'h00, 0, -1, 0,
        lat, seen, acks, q0, sc, pc, b1, r1);
    chk("start2_owned", bus_owned, 1);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = I2C_READ;
    cmd_if.cmd_nack  = 1'b0;
    slave_low = 1'b0;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (86) @(posedge clk);
    #1;
    chk("rd5_pre_scl_oe", scl_oe, 1);
    chk("rd5_pre_busy", busy, 1);
    rst_ = 1'b0;
    #1;
    chk("rd5_rst_scl_oe", scl_oe, 0);
    chk("rd5_rst_sda_oe", sda_oe, 0);
    chk("rd5_rst_ready", cmd_if.cmd_ready, 1);
    chk("rd5_rst_owned", bus_owned, 0);
    chk("rd5_rst_rsp", cmd_if.rsp_valid, 0);
    @(negedge clk);
    rst_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
